// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single data-memory port between the core load/store path and
//   the loader/debug port. At most one requester is granted per cycle. The
//   grant is combinational. A registered owner/run-length pair limits how
//   long one side can keep the port while the other side waits.
//
// Optional feature macro: DMEM_ARB_STATS_EN (adds the stall_cnt output)
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   core_req/we/addr/wdata  core access request
//   core_rdata          load data to core (mirrors mem_out)
//   core_stall          core access not performed this cycle
//   ldr_req/we/addr/wdata   loader access request
//   ldr_rdata           read data to loader (mirrors mem_out)
//   ldr_ack             loader access performed this cycle
//   mem_addr/mem_in/mem_wr_en  to data memory
//   mem_out             combinational read data from memory
//   stall_cnt           (DMEM_ARB_STATS_EN only) saturating stalled-cycle count
//
// State | meaning
//   OWN_CORE | core held the port most recently (also the reset owner)
//   OWN_LDR  | loader held the port most recently
//   run_cnt counts consecutive grants to the owner and saturates at HOLD_MAX.

module dmem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_stall,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic [DW-1:0] ldr_rdata,
  output logic          ldr_ack,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_in,
  output logic          mem_wr_en,
  input  logic [DW-1:0] mem_out
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_LDR  = 1'b1
  } owner_t;

  localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

  owner_t     owner_q, owner_d;
  logic [3:0] run_cnt_q, run_cnt_d;
  logic       grant_core, grant_ldr;
  logic       grant_owner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q   <= OWN_CORE;
      run_cnt_q <= 4'd0;
    end else begin
      owner_q   <= owner_d;
      run_cnt_q <= run_cnt_d;
    end
  end

  // Grant selection. Under contention the owner keeps the port until it has
  // used up its run. The run is not cleared while the owner is uncontested,
  // so a long solo run gives the port away as soon as the other side arrives.
  always_comb begin
    grant_core = 1'b0;
    grant_ldr  = 1'b0;
    if (core_req && ldr_req) begin
      if (run_cnt_q < HOLD_LIM) begin
        grant_core = (owner_q == OWN_CORE);
        grant_ldr  = (owner_q == OWN_LDR);
      end else begin
        grant_core = (owner_q == OWN_LDR);
        grant_ldr  = (owner_q == OWN_CORE);
      end
    end else begin
      grant_core = core_req;
      grant_ldr  = ldr_req;
    end
  end

  assign grant_owner = (grant_core && (owner_q == OWN_CORE)) ||
                       (grant_ldr  && (owner_q == OWN_LDR));

  always_comb begin
    owner_d   = owner_q;
    run_cnt_d = run_cnt_q;
    if (!grant_core && !grant_ldr) begin
      run_cnt_d = 4'd0;
    end else if (grant_owner) begin
      if (run_cnt_q < HOLD_LIM) run_cnt_d = run_cnt_q + 4'd1;
    end else begin
      owner_d   = grant_ldr ? OWN_LDR : OWN_CORE;
      run_cnt_d = 4'd1;
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_in    = '0;
    mem_wr_en = 1'b0;
    if (grant_core) begin
      mem_addr  = core_addr;
      mem_in    = core_wdata;
      mem_wr_en = core_we;
    end else if (grant_ldr) begin
      mem_addr  = ldr_addr;
      mem_in    = ldr_wdata;
      mem_wr_en = ldr_we;
    end
    // The strobe drops the moment reset asserts, even mid-access.
    if (!rst_n) mem_wr_en = 1'b0;
  end

  assign core_stall = core_req & ~grant_core;
  assign ldr_ack    = grant_ldr;
  assign core_rdata = mem_out;
  assign ldr_rdata  = mem_out;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'd0;
    end else if (core_stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       core_req, core_we;
  logic [7:0] core_addr, core_wdata, core_rdata;
  logic       core_stall;
  logic       ldr_req, ldr_we;
  logic [7:0] ldr_addr, ldr_wdata, ldr_rdata;
  logic       ldr_ack;
  logic [7:0] mem_addr, mem_in, mem_out;
  logic       mem_wr_en;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  byte exp_q[$];

  logic [7:0] mem [256];

  always #5 clk = ~clk;

  assign mem_out = mem[mem_addr];
  always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_in;

  dmem_arbiter #(.AW(8), .DW(8), .HOLD_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr),
    .ldr_wdata(ldr_wdata), .ldr_rdata(ldr_rdata), .ldr_ack(ldr_ack),
    .mem_addr(mem_addr), .mem_in(mem_in), .mem_wr_en(mem_wr_en),
    .mem_out(mem_out)
`ifdef DMEM_ARB_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // Observed grant: C = core access performed, L = loader, N = none, X = both
  function automatic byte obs_grant();
    logic gc;
    gc = core_req && !core_stall;
    if (gc && ldr_ack) return "X";
    if (gc) return "C";
    if (ldr_ack) return "L";
    return "N";
  endfunction

  task automatic set_core(input logic req, input logic we, input logic [7:0] a, input logic [7:0] d);
    core_req = req; core_we = we; core_addr = a; core_wdata = d;
  endtask

  task automatic set_ldr(input logic req, input logic we, input logic [7:0] a, input logic [7:0] d);
    ldr_req = req; ldr_we = we; ldr_addr = a; ldr_wdata = d;
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1;
    set_core(0, 0, 0, 0); set_ldr(0, 0, 0, 0);
    rst_n = 1'b0; #2; rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_core(1, 1, 8'h44, 8'h55); set_ldr(0, 0, 0, 0);
    #2;
    checks++;
    if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %0b want 0", mem_wr_en); end
    checks++;
    if (core_stall !== 1'b0) begin errors++; $display("FAIL reset_core_stall got %0b want 0", core_stall); end
    checks++;
    if (ldr_ack !== 1'b0) begin errors++; $display("FAIL reset_ldr_ack got %0b want 0", ldr_ack); end
    set_core(0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_core_write();
    byte e, g;
    @(posedge clk); #1;
    set_core(1, 1, 8'h10, 8'hA5); set_ldr(0, 0, 0, 0);
    exp_q.push_back("C");
    @(negedge clk);
    e = exp_q.pop_front(); g = obs_grant();
    checks++;
    if (g !== e) begin errors++; $display("FAIL cw_grant got %c want %c", g, e); end
    checks++;
    if (mem_wr_en !== 1'b1) begin errors++; $display("FAIL cw_wr_en got %0b want 1", mem_wr_en); end
    checks++;
    if (mem_addr !== 8'h10) begin errors++; $display("FAIL cw_addr got %0h want 10", mem_addr); end
    checks++;
    if (mem_in !== 8'hA5) begin errors++; $display("FAIL cw_data got %0h want a5", mem_in); end
    checks++;
    if (core_stall !== 1'b0) begin errors++; $display("FAIL cw_stall got %0b want 0", core_stall); end
    @(posedge clk); #1;
    set_core(0, 0, 0, 0);
    checks++;
    if (mem[8'h10] !== 8'hA5) begin errors++; $display("FAIL cw_mem got %0h want a5", mem[8'h10]); end
  endtask

  task automatic test_ldr_read();
    byte e, g;
    @(posedge clk); #1;
    set_core(0, 0, 0, 0); set_ldr(1, 0, 8'h20, 8'hFF);
    exp_q.push_back("L");
    @(negedge clk);
    e = exp_q.pop_front(); g = obs_grant();
    checks++;
    if (g !== e) begin errors++; $display("FAIL lr_grant got %c want %c", g, e); end
    checks++;
    if (ldr_ack !== 1'b1) begin errors++; $display("FAIL lr_ack got %0b want 1", ldr_ack); end
    checks++;
    if (ldr_rdata !== 8'h3C) begin errors++; $display("FAIL lr_rdata got %0h want 3c", ldr_rdata); end
    checks++;
    if (core_rdata !== 8'h3C) begin errors++; $display("FAIL lr_core_rdata got %0h want 3c", core_rdata); end
    checks++;
    if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL lr_wr_en got %0b want 0", mem_wr_en); end
    @(posedge clk); #1;
    set_ldr(1, 0, 8'h10, 8'h00);
    exp_q.push_back("L");
    @(negedge clk);
    e = exp_q.pop_front(); g = obs_grant();
    checks++;
    if (g !== e) begin errors++; $display("FAIL lr2_grant got %c want %c", g, e); end
    checks++;
    if (ldr_rdata !== 8'hA5) begin errors++; $display("FAIL lr2_rdata got %0h want a5", ldr_rdata); end
    @(posedge clk); #1;
    set_ldr(0, 0, 0, 0);
  endtask

  // Drives a pattern of request pairs; expected grants come from exp_pat.
  task automatic test_contention();
    string exp_pat;
    byte e, g;
    exp_pat = "CCCCLLLLCCCCL";
    reset_pulse();
    for (int i = 0; i < exp_pat.len(); i++) begin
      @(posedge clk); #1;
      set_core(1, 0, 8'h01, 8'h00); set_ldr(1, 0, 8'h02, 8'h00);
      exp_q.push_back(exp_pat[i]);
      @(negedge clk);
      e = exp_q.pop_front(); g = obs_grant();
      checks++;
      if (g !== e) begin errors++; $display("FAIL cont_grant[%0d] got %c want %c", i, g, e); end
      checks++;
      if (core_stall !== (e == "L")) begin errors++; $display("FAIL cont_stall[%0d] got %0b want %0b", i, core_stall, (e == "L")); end
      checks++;
      if (mem_addr !== ((e == "L") ? 8'h02 : 8'h01)) begin errors++; $display("FAIL cont_addr[%0d] got %0h", i, mem_addr); end
    end
    @(posedge clk); #1;
    set_core(0, 0, 0, 0); set_ldr(0, 0, 0, 0);
  endtask

  task automatic test_join_after_run();
    string exp_pat;
    byte e, g;
    exp_pat = "CCCCCCCCCCLCCCC";
    reset_pulse();
    for (int i = 0; i < exp_pat.len(); i++) begin
      @(posedge clk); #1;
      set_core(1, 0, 8'h05, 8'h00); set_ldr((i == 10), 0, 8'h06, 8'h00);
      exp_q.push_back(exp_pat[i]);
      @(negedge clk);
      e = exp_q.pop_front(); g = obs_grant();
      checks++;
      if (g !== e) begin errors++; $display("FAIL join_grant[%0d] got %c want %c", i, g, e); end
    end
    @(posedge clk); #1;
    set_core(0, 0, 0, 0); set_ldr(0, 0, 0, 0);
  endtask

  // Loader joins after the core has 2 grants: core completes its run of 4.
  task automatic test_hold_boundary();
    string exp_pat;
    byte e, g;
    exp_pat = "CCCCLLLLC";
    reset_pulse();
    for (int i = 0; i < exp_pat.len(); i++) begin
      @(posedge clk); #1;
      set_core(1, 0, 8'h07, 8'h00); set_ldr((i >= 2), 0, 8'h08, 8'h00);
      exp_q.push_back(exp_pat[i]);
      @(negedge clk);
      e = exp_q.pop_front(); g = obs_grant();
      checks++;
      if (g !== e) begin errors++; $display("FAIL bound_grant[%0d] got %c want %c", i, g, e); end
    end
    @(posedge clk); #1;
    set_core(0, 0, 0, 0); set_ldr(0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_write();
    byte e, g;
    @(posedge clk); #1;
    set_core(0, 0, 0, 0); set_ldr(1, 1, 8'h30, 8'h77);
    exp_q.push_back("L");
    @(negedge clk);
    e = exp_q.pop_front(); g = obs_grant();
    checks++;
    if (g !== e) begin errors++; $display("FAIL rmw_grant got %c want %c", g, e); end
    checks++;
    if (mem_wr_en !== 1'b1) begin errors++; $display("FAIL rmw_wr_pre got %0b want 1", mem_wr_en); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL rmw_wr_rst got %0b want 0", mem_wr_en); end
    @(posedge clk); #1;
    set_ldr(0, 0, 0, 0);
    rst_n = 1'b1;
    checks++;
    if (mem[8'h30] !== 8'h00) begin errors++; $display("FAIL rmw_mem got %0h want 0", mem[8'h30]); end
    set_core(1, 0, 8'h01, 8'h00); set_ldr(1, 0, 8'h02, 8'h00);
    exp_q.push_back("C");
    @(negedge clk);
    e = exp_q.pop_front(); g = obs_grant();
    checks++;
    if (g !== e) begin errors++; $display("FAIL rmw_first got %c want %c", g, e); end
    @(posedge clk); #1;
    set_core(0, 0, 0, 0); set_ldr(0, 0, 0, 0);
  endtask

`ifdef DMEM_ARB_STATS_EN
  task automatic test_stats();
    reset_pulse();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      set_core(1, 0, 8'h01, 8'h00); set_ldr(1, 0, 8'h02, 8'h00);
    end
    @(posedge clk); #1;
    set_core(0, 0, 0, 0); set_ldr(0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (stall_cnt !== 16'd4) begin errors++; $display("FAIL stats_cnt got %0d want 4", stall_cnt); end
    force dut.stall_cnt_q = 16'hFFFF;
    #1 release dut.stall_cnt_q;
    @(posedge clk); #1;
    set_core(1, 0, 8'h01, 8'h00); set_ldr(1, 0, 8'h02, 8'h00);
    @(negedge clk);
    checks++;
    if (core_stall !== 1'b1) begin errors++; $display("FAIL stats_stall got %0b want 1", core_stall); end
    @(posedge clk); #1;
    set_core(0, 0, 0, 0); set_ldr(0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL stats_sat got %0h want ffff", stall_cnt); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h20] = 8'h3C;
    test_reset();
    test_core_write();
    test_ldr_read();
    test_contention();
    test_join_after_run();
    test_hold_boundary();
    test_reset_mid_write();
`ifdef DMEM_ARB_STATS_EN
    test_stats();
`endif
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbitrates the single data-memory port between the core's load/store path and the loader/debug port that fills memory before a run and dumps it afterward. Each cycle the block grants the port to at most one requester. It muxes that requester's address, write data and write enable onto the memory. A registered owner/run-length state machine bounds how long either side can monopolise the port. It sits between the control/datapath memory signals and the data memory, and stalls the core PC when the core loses arbitration.

## Interface
- `AW`, default 8: address width.
- `DW`, default 8: data width.
- `HOLD_MAX`, default 4: maximum consecutive grants to one requester while the other waits; legal range 1–15.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `core_req`  in  1  core requests a memory access this cycle.
- `core_we`  in  1  1 = store, 0 = load.
- `core_addr`  in  AW  core access address.
- `core_wdata`  in  DW  core store data.
- `core_rdata`  out  DW  load data to the core (= `mem_out`).
- `core_stall`  out  1  core access not performed this cycle; core must hold the request.
- `ldr_req`  in  1  loader requests an access.
- `ldr_we`  in  1  1 = write, 0 = read.
- `ldr_addr`  in  AW  loader address.
- `ldr_wdata`  in  DW  loader write data.
- `ldr_rdata`  out  DW  read data to the loader (= `mem_out`).
- `ldr_ack`  out  1  loader access performed this cycle.
- `mem_addr`  out  AW  to data memory.
- `mem_in`  out  DW  write data to data memory.
- `mem_wr_en`  out  1  memory write strobe, sampled by the memory at the next edge.
- `mem_out`  in  DW  combinational read data from memory.

## Operation
- Registered state: `owner` (0 = core, 1 = loader) and `run_cnt` (4 bits, saturates at `HOLD_MAX`).
- Grant is combinational from requests and registered state:
  - No request: no grant.
  - One request: that requester is granted.
  - Both requesting, `owner` requesting and `run_cnt < HOLD_MAX`: `owner` is granted.
  - Both requesting, otherwise: the non-owner is granted.
- State update at each edge:
  - Grant to `owner`: `run_cnt` increments, saturating.
  - Grant to the other requester: `owner` takes that requester and `run_cnt` becomes 1.
  - No grant: `owner` is held and `run_cnt` clears to 0.
- The run count is not reset while uncontested. If the owner has held the port for at least `HOLD_MAX` cycles when the other side arrives, the port switches immediately.
- Muxing: the granted requester's `addr`, `wdata` and `we` drive `mem_addr`, `mem_in` and `mem_wr_en`. With no grant, all three are 0.
- `core_stall = core_req & ~grant_core`. `ldr_ack = grant_ldr`.
- Both rdata outputs always mirror `mem_out`. A read result is valid only in the cycle in which that requester is granted.
- Requesters must hold `req`, `addr`, `we` and `wdata` stable until granted. Changing them before the grant is a protocol violation, with undefined results.
- Because only one requester is granted per cycle, there are no write-write collisions.

## Timing
- Grant latency is 0 cycles. An uncontested request completes in the same cycle.
- Worst-case wait for a requester under continuous contention is `HOLD_MAX` cycles.
- Reset values: `owner` = 0, `run_cnt` = 0. All outputs follow combinationally from the reset state and the inputs. `mem_wr_en` is forced to 0 while `rst_n` is low.
- Reset asserted mid-access: the write strobe drops immediately. After release, arbitration restarts with `owner` = core and `run_cnt` = 0.
- Simultaneous first requests after reset: the core wins, because `owner` = 0 and `run_cnt` = 0 < `HOLD_MAX`.

## Configuration
- `DMEM_ARB_STATS_EN` defined: adds output `stall_cnt` (16 bits), which counts cycles with `core_stall` = 1. It saturates at 0xFFFF and resets to 0.
- `DMEM_ARB_STATS_EN` undefined: the port and the counter are absent. Arbitration behaviour is identical in both cases.

## Test plan
- Reset, then `core_req` = 1 only, `core_we` = 1, addr 0x10, data 0xA5 -> `mem_wr_en` = 1, `mem_addr` = 0x10, `mem_in` = 0xA5, `core_stall` = 0 in the same cycle.
- `ldr_req` = 1 only, read addr 0x20, with memory holding 0x3C -> `ldr_ack` = 1 and `ldr_rdata` = 0x3C in the same cycle.
- Both requesting continuously with `HOLD_MAX` = 4, starting from reset -> grant pattern C, C, C, C, L, L, L, L, C…. `core_stall` = 1 exactly in the loader cycles.
- Core alone for 10 cycles, then the loader joins -> loader granted on its first cycle. The core then gets the next 4 grants.
- Reset asserted during a granted loader write -> `mem_wr_en` = 0 immediately. After release, simultaneous requests grant the core first.
- With `DMEM_ARB_STATS_EN`: 8 contested cycles -> `stall_cnt` = 4. Force 0xFFFF plus one more stall cycle -> `stall_cnt` holds at 0xFFFF.
